// File: rtl/dot_product_row_sequencer.sv
// Row/package sequencer for the 8-element dot-product unit: streams matrix and
// vector packages into the DPU and writes one 32-bit result per matrix row.
module dot_product_row_sequencer #(
  parameter int NOE     = 10,
  parameter int NI      = 8,
  parameter int AW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] num_rows,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          mat_rd_en,
  output logic [AW-1:0] mat_addr,
  output logic          vec_rd_en,
  output logic [AW-1:0] vec_addr,
  output logic          dpu_read_now,
  output logic [31:0]   dpu_no_of_multiples,
  input  logic          dpu_ready,
  input  logic          dpu_finish,
  input  logic [31:0]   dpu_result,
  output logic          dpu_reset,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [31:0]   res_data
);

  localparam int PKGS = (NOE + NI - 1) / NI;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_FIRE     = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_WAIT_RES = 3'd4;
  localparam logic [2:0] S_STORE    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [AW-1:0] PKG_LAST = AW'(PKGS - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [31:0]   WD_LIMIT = 32'(TIMEOUT - 1);

  logic [2:0]    state, state_nx;
  logic [AW-1:0] row, pkg, rows_q;
  logic [31:0]   wd;
  logic          err_q, rst_pulse_q;
  logic [31:0]   res_q;

  logic wd_active, wd_expired, hold_exit, row_last, leave_early;

  assign wd_active   = (state == S_HOLD) || (state == S_WAIT_RES);
  assign wd_expired  = wd_active && (wd == WD_LIMIT);
  // The watchdog count doubles as the HOLD dwell timer: wd != 0 means 2nd cycle or later.
  assign hold_exit   = dpu_ready && (wd != '0);
  assign row_last    = (row == rows_q - ONE);
  assign leave_early = (state != S_IDLE) && (abort || wd_expired);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = (num_rows == '0) ? S_DONE : S_RD;
      S_RD:       state_nx = S_FIRE;
      S_FIRE:     state_nx = S_HOLD;
      S_HOLD:     if (hold_exit) state_nx = (pkg == PKG_LAST) ? S_WAIT_RES : S_RD;
      S_WAIT_RES: if (dpu_finish) state_nx = S_STORE;
      S_STORE:    state_nx = row_last ? S_DONE : S_RD;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
    if (leave_early) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      row         <= '0;
      pkg         <= '0;
      rows_q      <= '0;
      wd          <= '0;
      err_q       <= 1'b0;
      rst_pulse_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state       <= state_nx;
      rst_pulse_q <= 1'b0;

      if (state_nx != state) wd <= '0;
      else if (wd_active)    wd <= wd + 32'd1;

      case (state)
        S_IDLE: if (start) begin
          rows_q <= num_rows;
          row    <= '0;
          pkg    <= '0;
          err_q  <= 1'b0;
        end
        S_HOLD: if (hold_exit && !leave_early) pkg <= (pkg == PKG_LAST) ? '0 : pkg + ONE;
        S_WAIT_RES: if (dpu_finish && !leave_early) res_q <= dpu_result;
        S_STORE: if (!row_last && !abort) row <= row + ONE;
        default: ;
      endcase

      // STORE already drives dpu_reset itself, so an abort there needs no extra pulse.
      if (state != S_IDLE) begin
        if (abort) begin
          rst_pulse_q <= (state != S_STORE);
        end else if (wd_expired) begin
          err_q       <= 1'b1;
          rst_pulse_q <= 1'b1;
        end
      end
    end
  end

  assign busy                = (state != S_IDLE);
  assign done                = (state == S_DONE);
  assign error               = err_q;
  assign mat_rd_en           = (state == S_RD);
  assign vec_rd_en           = (state == S_RD);
  assign mat_addr            = AW'(32'(row) * 32'(PKGS) + 32'(pkg));
  assign vec_addr            = pkg;
  assign dpu_read_now        = (state == S_FIRE);
  assign dpu_no_of_multiples = 32'(PKGS);
  assign dpu_reset           = (state == S_STORE) || rst_pulse_q;
  assign res_we              = (state == S_STORE);
  assign res_addr            = row;
  assign res_data            = res_q;

endmodule

// File: tb/tb_dot_product_row_sequencer.sv
// Self-checking bench for dot_product_row_sequencer: table-driven runs, directed
// corner sequences and randomized runs against a transaction-level expectation.
module tb_dot_product_row_sequencer;

  localparam int NOE  = 10;
  localparam int NI   = 8;
  localparam int AW   = 8;
  localparam int TO   = 16;
  localparam int PKGS = (NOE + NI - 1) / NI;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [AW-1:0] num_rows;
  logic          busy, done, error, mat_rd_en, vec_rd_en, dpu_read_now, dpu_reset, res_we;
  logic [AW-1:0] mat_addr, vec_addr, res_addr;
  logic [31:0]   dpu_no_of_multiples, res_data;
  logic          dpu_ready  = 1'b0;
  logic          dpu_finish = 1'b0;
  logic [31:0]   dpu_result = '0;

  always #5 clk = ~clk;

  dot_product_row_sequencer #(.NOE(NOE), .NI(NI), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_rows(num_rows),
    .busy(busy), .done(done), .error(error),
    .mat_rd_en(mat_rd_en), .mat_addr(mat_addr), .vec_rd_en(vec_rd_en), .vec_addr(vec_addr),
    .dpu_read_now(dpu_read_now), .dpu_no_of_multiples(dpu_no_of_multiples),
    .dpu_ready(dpu_ready), .dpu_finish(dpu_finish), .dpu_result(dpu_result),
    .dpu_reset(dpu_reset), .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
  );

  int    total = 0, bad = 0;
  string cur = "init";

  // stimulus knobs (written by the test process only)
  logic [31:0] res_tab [16];
  bit          stall = 0, rand_ready = 0;
  int          lat_cfg = 1, clr_gen = 0, s_cyc = 0;

  // event log and DPU model (written by the monitor process only)
  int cyc = 0, seen_gen = 0;
  int rd_q[$], vq[$], wa_q[$];
  logic [31:0] wdat_q[$];
  int fires, min_gap, last_fire, last_we_cyc, done_cnt, done_cyc, rst_cnt;
  int first_rst_cyc, err_cyc, first_busy_cyc;
  int pend = 0, lat_left = 0, row_idx = 0;
  bit fin = 0;

  always @(negedge clk) begin
    cyc++;
    if (seen_gen != clr_gen) begin
      rd_q.delete(); vq.delete(); wa_q.delete(); wdat_q.delete();
      fires = 0; min_gap = 1000; last_fire = -1000; last_we_cyc = -1;
      done_cnt = 0; done_cyc = -1; rst_cnt = 0; first_rst_cyc = -1;
      err_cyc = -1; first_busy_cyc = -1;
      pend = 0; fin = 0; lat_left = lat_cfg; row_idx = 0;
      seen_gen = clr_gen;
    end
    if (mat_rd_en) begin rd_q.push_back(int'(mat_addr)); vq.push_back(int'(vec_addr)); end
    if (dpu_read_now) begin
      fires++;
      if (cyc - last_fire < min_gap) min_gap = cyc - last_fire;
      last_fire = cyc;
    end
    if (res_we) begin wa_q.push_back(int'(res_addr)); wdat_q.push_back(res_data); last_we_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (dpu_reset) begin rst_cnt++; if (first_rst_cyc < 0) first_rst_cyc = cyc; end
    if (error && err_cyc < 0) err_cyc = cyc;
    if (busy && first_busy_cyc < 0) first_busy_cyc = cyc;
    // DPU: result becomes valid lat_cfg cycles after the last package of a row
    if (!reset || dpu_reset) begin
      pend = 0; fin = 0; lat_left = lat_cfg;
      if (reset && dpu_reset) row_idx++;
    end else begin
      if (dpu_read_now) pend++;
      if (pend >= PKGS && !fin) begin
        if (lat_left <= 0) fin = 1; else lat_left--;
      end
    end
    dpu_finish = fin && !stall;
    dpu_result = res_tab[row_idx % 16];
    dpu_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s/%s: actual=%0h required=%0h", cur, name, act, exp);
    end
  endtask

  task automatic clear_log();
    clr_gen++;
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    num_rows = AW'(n); start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    #1;
    check("idle_within_budget", ok, 1);
  endtask

  task automatic check_all_zero();
    check("z_busy", busy, 0);         check("z_done", done, 0);
    check("z_error", error, 0);       check("z_mat_rd_en", mat_rd_en, 0);
    check("z_mat_addr", mat_addr, 0); check("z_vec_rd_en", vec_rd_en, 0);
    check("z_vec_addr", vec_addr, 0); check("z_read_now", dpu_read_now, 0);
    check("z_dpu_reset", dpu_reset, 0); check("z_res_we", res_we, 0);
    check("z_res_addr", res_addr, 0); check("z_res_data", res_data, 0);
    check("z_multiples", dpu_no_of_multiples, PKGS);
  endtask

  task automatic verify(input int n, input int er, input int ew, input int ers, input int ed);
    int idx = 0;
    check("busy_idle", busy, 0);
    check("error_clear", error, 0);
    check("reads", rd_q.size(), er);
    check("fires", fires, er);
    check("writes", wa_q.size(), ew);
    check("dpu_resets", rst_cnt, ers);
    check("dones", done_cnt, ed);
    check("busy_rise", first_busy_cyc, s_cyc + 2);
    for (int r = 0; r < n; r++)
      for (int p = 0; p < PKGS; p++) begin
        if (idx < rd_q.size()) begin
          check("mat_addr", rd_q[idx], (r * PKGS + p) % (1 << AW));
          check("vec_addr", vq[idx], p);
        end
        idx++;
      end
    for (int r = 0; r < n && r < wa_q.size(); r++) begin
      check("res_addr", wa_q[r], r);
      check("res_data", wdat_q[r], res_tab[r]);
    end
    if (n > 0) check("done_after_last_we", done_cyc, last_we_cyc + 1);
    else       check("empty_done_latency", done_cyc, s_cyc + 2);
    if (er > 1) check("fire_gap_ge4", (min_gap >= 4), 1);
  endtask

  task automatic run_and_verify(input int n, input int er, input int ew, input int ers, input int ed);
    clear_log();
    pulse_start(n);
    wait_idle(500);
    verify(n, er, ew, ers, ed);
  endtask

  typedef struct {
    int          n;
    logic [31:0] base;
    logic [31:0] step;
    bit          rnd_ready;
    int          lat;
    int          exp_reads;
    int          exp_writes;
    int          exp_resets;
    int          exp_done;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n, seen;
    tbl[0] = '{1, 32'h3F800000, 32'd0, 1'b0, 2, 2, 1, 1, 1};
    tbl[1] = '{3, 32'd0,        32'd1, 1'b0, 1, 6, 3, 3, 1};
    tbl[2] = '{0, 32'd0,        32'd0, 1'b0, 1, 0, 0, 0, 1};
    tbl[3] = '{5, 32'h100,      32'd7, 1'b1, 3, 10, 5, 5, 1};
    tbl[4] = '{2, 32'hDEAD0000, 32'd1, 1'b1, 0, 4, 2, 2, 1};
    for (int r = 0; r < 16; r++) res_tab[r] = '0;

    reset = 1'b0; start = 1'b0; abort = 1'b0; num_rows = '0;
    repeat (3) @(posedge clk);
    #1;
    cur = "reset";
    check_all_zero();
    reset = 1'b1;

    for (int t = 0; t < 5; t++) begin
      cur = $sformatf("tbl%0d", t);
      for (int r = 0; r < 16; r++) res_tab[r] = tbl[t].base + tbl[t].step * 32'(r);
      rand_ready = tbl[t].rnd_ready;
      lat_cfg    = tbl[t].lat;
      run_and_verify(tbl[t].n, tbl[t].exp_reads, tbl[t].exp_writes, tbl[t].exp_resets, tbl[t].exp_done);
    end

    // second start while busy must be ignored
    cur = "busy_start";
    rand_ready = 0; lat_cfg = 1;
    for (int r = 0; r < 16; r++) res_tab[r] = 32'hA000 + 32'(r);
    clear_log();
    pulse_start(2);
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid_run", busy, 1);
    num_rows = AW'(7); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(500);
    verify(2, 4, 2, 2, 1);

    // watchdog: DPU never finishes
    cur = "watchdog";
    stall = 1;
    clear_log();
    pulse_start(1);
    wait_idle(200);
    check("wd_error_cycle", err_cyc, last_fire + 3 + TO);
    check("wd_reset_cycle", first_rst_cyc, last_fire + 3 + TO);
    check("wd_error", error, 1);
    check("wd_no_done", done_cnt, 0);
    check("wd_no_we", wa_q.size(), 0);
    check("wd_one_reset", rst_cnt, 1);
    stall = 0;
    clear_log();
    pulse_start(1);
    @(negedge clk);
    check("wd_error_cleared", error, 0);
    wait_idle(500);
    verify(1, 2, 1, 1, 1);

    // abort in HOLD of row 1, package 1
    cur = "abort";
    clear_log();
    pulse_start(3);
    seen = 0;
    for (int i = 0; i < 200 && seen < PKGS + 2; i++) begin
      @(negedge clk);
      if (dpu_read_now) seen++;
    end
    check("abort_reached_pkg", seen, PKGS + 2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 0);
    check("abort_dpu_reset", dpu_reset, 1);
    @(negedge clk);
    check("abort_reset_one_cycle", dpu_reset, 0);
    #1;
    check("abort_writes", wa_q.size(), 1);
    if (wa_q.size() > 0) check("abort_row0_addr", wa_q[0], 0);
    check("abort_resets", rst_cnt, 2);
    check("abort_no_done", done_cnt, 0);
    check("abort_error", error, 0);

    // asynchronous reset during WAIT_RES
    cur = "async_reset";
    stall = 1;
    clear_log();
    pulse_start(1);
    seen = 0;
    for (int i = 0; i < 200 && seen < PKGS; i++) begin
      @(negedge clk);
      if (dpu_read_now) seen++;
    end
    repeat (4) @(negedge clk);
    check("ar_busy_before", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero();
    @(posedge clk); #1;
    reset = 1'b1;
    stall = 0;
    for (int r = 0; r < 16; r++) res_tab[r] = 32'h5A5A0000 + 32'(r);
    run_and_verify(1, 2, 1, 1, 1);

    // randomized runs
    for (int k = 0; k < 20; k++) begin
      cur = $sformatf("rnd%0d", k);
      n = $urandom_range(1, 6);
      for (int r = 0; r < 16; r++) res_tab[r] = $urandom;
      rand_ready = ($urandom_range(0, 1) == 1);
      lat_cfg    = $urandom_range(0, 5);
      run_and_verify(n, n * PKGS, n, n, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
